// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-master data-RAM arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

  localparam int N_MASTERS = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Requester-side and RAM-side bundles of the data-RAM arbiter.
// Requester: req held until gnt; read data returns one cycle after the beat.
interface dmem_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              wr;
  logic              oe;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output wr, oe, address, data_in, input data_out);
  modport slave  (input wr, oe, address, data_in, output data_out);
endinterface

// File: rtl/dmem_arb_mux.sv
// Combinational RAM request mux (by owner) and read-data demux (by rd_tag).
// Zero latency; a beat exists only when the owner requests, otherwise RAM lines are 0.
module dmem_arb_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic        own_vld,
  input  logic        own_idx,
  input  logic        rd_pend,
  input  logic        rd_tag,
  dmem_arb_if.slave   m0,
  dmem_arb_if.slave   m1,
  dmem_ram_if.master  ram
);

  logic              req_sel;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              beat;
  logic              rv0;
  logic              rv1;

  assign req_sel   = own_idx ? m1.req   : m0.req;
  assign we_sel    = own_idx ? m1.we    : m0.we;
  assign addr_sel  = own_idx ? m1.addr  : m0.addr;
  assign wdata_sel = own_idx ? m1.wdata : m0.wdata;
  assign beat      = own_vld & req_sel;

  assign m0.gnt = own_vld & ~own_idx & m0.req;
  assign m1.gnt = own_vld &  own_idx & m1.req;

  assign ram.wr      = beat &  we_sel;
  assign ram.oe      = beat & ~we_sel;
  assign ram.address = beat ? addr_sel  : '0;
  assign ram.data_in = beat ? wdata_sel : '0;

  // Return path follows the tag captured at the read beat, not the current owner.
  assign rv0       = rd_pend & ~rd_tag;
  assign rv1       = rd_pend &  rd_tag;
  assign m0.rvalid = rv0;
  assign m1.rvalid = rv1;
  assign m0.rdata  = rv0 ? ram.data_out : '0;
  assign m1.rdata  = rv1 ? ram.data_out : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin owner-hold arbiter for one data RAM port; 1 cycle REQ-to-first-GNT, reads return next cycle.
// Owner keeps the port until it drops REQ or hits MAX_BURST beats while the other master waits.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int MAX_BURST = 8
) (
  input  logic       CLK,
  input  logic       RSTa,
  dmem_arb_if.slave  m0,
  dmem_arb_if.slave  m1,
  dmem_ram_if.master ram
);

  arb_state_t           state_q, state_d;
  logic                 last_owner_q, last_owner_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_tag_q, rd_tag_d;
  logic [N_MASTERS-1:0] req_vec;
  logic                 own_vld;
  logic                 own_idx;
  logic                 req_own;
  logic                 req_oth;
  logic                 we_own;
  logic                 cap_hit;
  arb_state_t           oth_state;

  assign req_vec   = {m1.req, m0.req};
  assign own_vld   = (state_q == OWN0) || (state_q == OWN1);
  assign own_idx   = (state_q == OWN1);
  assign req_own   = req_vec[own_idx];
  assign req_oth   = req_vec[~own_idx];
  assign we_own    = own_idx ? m1.we : m0.we;
  assign oth_state = own_idx ? OWN0 : OWN1;
  // Widened compare so a counter that saturated while alone still yields on contention.
  assign cap_hit   = ({1'b0, beat_cnt_q} + 9'd1) >= 9'(MAX_BURST);

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b0;
      beat_cnt_q   <= 8'd0;
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    rd_pend_d    = 1'b0;
    rd_tag_d     = rd_tag_q;
    case (state_q)
      IDLE: begin
        beat_cnt_d = 8'd0;
        if (req_vec == 2'b11) state_d = last_owner_q ? OWN0 : OWN1;
        else if (req_vec[0])  state_d = OWN0;
        else if (req_vec[1])  state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!req_own) begin
          state_d      = req_oth ? oth_state : IDLE;
          last_owner_d = own_idx;
          beat_cnt_d   = 8'd0;
        end else begin
          rd_pend_d = ~we_own;
          if (!we_own) rd_tag_d = own_idx;
          if (cap_hit && req_oth) begin
            state_d      = oth_state;
            last_owner_d = own_idx;
            beat_cnt_d   = 8'd0;
          end else begin
            beat_cnt_d = sat_inc8(beat_cnt_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dmem_arb_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mux (
    .own_vld (own_vld),
    .own_idx (own_idx),
    .rd_pend (rd_pend_q),
    .rd_tag  (rd_tag_q),
    .m0      (m0),
    .m1      (m1),
    .ram     (ram)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + random traffic on both masters, every cycle checked against a transaction-level
// model of ownership, burst caps and read returns, plus targeted checks of the listed scenarios.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MB = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic CLK  = 1'b0;
  logic RSTa = 1'b0;
  always #5 CLK = ~CLK;

  dmem_arb_if #(.DATA_W(DW), .ADDR_W(AW)) m0_if ();
  dmem_arb_if #(.DATA_W(DW), .ADDR_W(AW)) m1_if ();
  dmem_ram_if #(.DATA_W(DW), .ADDR_W(AW)) ram_if ();

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .CLK  (CLK),
    .RSTa (RSTa),
    .m0   (m0_if),
    .m1   (m1_if),
    .ram  (ram_if)
  );

  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];

  assign m0_if.req = req[0];  assign m0_if.we = we[0];  assign m0_if.addr = addr[0];  assign m0_if.wdata = wdata[0];
  assign m1_if.req = req[1];  assign m1_if.we = we[1];  assign m1_if.addr = addr[1];  assign m1_if.wdata = wdata[1];

  // RAM fixture: synchronous read, contents re-seeded while reset is held.
  logic [DW-1:0] ram_mem [1 << AW];
  always @(posedge CLK) begin
    if (!RSTa) begin
      for (int k = 0; k < (1 << AW); k++) ram_mem[k] <= 32'hA000_0000 + DW'(k);
    end else begin
      if (ram_if.wr) ram_mem[ram_if.address] <= ram_if.data_in;
      if (ram_if.oe) ram_if.data_out <= ram_mem[ram_if.address];
    end
  end

  // Reference model state (-1 = nobody)
  int            m_owner, m_last, m_beats, m_rd_who;
  logic [DW-1:0] m_rd_val;
  logic [DW-1:0] ref_mem [1 << AW];

  logic          e_gnt [2], e_rv [2], e_wr, e_oe;
  logic [DW-1:0] e_rd  [2], e_din;
  logic [AW-1:0] e_addr;
  logic          o_gnt [2], o_rv [2], o_wr, o_oe;
  logic [DW-1:0] o_rd  [2], o_din;
  logic [AW-1:0] o_addr;

  txn_t q0[$], q1[$];
  int   nchecks = 0, nerr = 0;
  int   cyc, cnt_wr, cnt_rv [2], first_gnt [2], first_rv [2], wt [2], max_wait [2];
  logic [DW-1:0] rd_seq0[$];
  int   run_own[$], run_len[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic txn_t qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int i, input txn_t t);
    if (i == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  function automatic txn_t mk(input logic w, input int a, input logic [DW-1:0] d);
    txn_t t;
    t.we = w; t.addr = AW'(a); t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom_range(0, 1)), int'($urandom_range(32, 63)), $urandom);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_beats = 0; m_rd_who = -1; m_rd_val = '0;
    for (int k = 0; k < (1 << AW); k++) ref_mem[k] = 32'hA000_0000 + DW'(k);
  endtask

  task automatic model_eval();
    e_gnt[0] = 0; e_gnt[1] = 0; e_wr = 0; e_oe = 0; e_addr = '0; e_din = '0;
    if (m_owner >= 0 && req[m_owner]) begin
      e_gnt[m_owner] = 1; e_wr = we[m_owner]; e_oe = !we[m_owner];
      e_addr = addr[m_owner]; e_din = wdata[m_owner];
    end
    for (int i = 0; i < 2; i++) begin
      e_rv[i] = (m_rd_who == i);
      e_rd[i] = e_rv[i] ? m_rd_val : '0;
    end
  endtask

  task automatic model_update();
    int nxt_rd;
    int o;
    int x;
    nxt_rd = -1;
    if (m_owner < 0) begin
      if (req[0] && req[1]) m_owner = 1 - m_last;
      else if (req[0])      m_owner = 0;
      else if (req[1])      m_owner = 1;
      m_beats = 0;
    end else begin
      o = m_owner; x = 1 - o;
      if (!req[o]) begin
        m_last = o; m_beats = 0; m_owner = req[x] ? x : -1;
      end else begin
        if (we[o]) ref_mem[addr[o]] = wdata[o];
        else begin nxt_rd = o; m_rd_val = ref_mem[addr[o]]; end
        m_beats++;
        if (m_beats >= MB && req[x]) begin m_last = o; m_owner = x; m_beats = 0; end
      end
    end
    m_rd_who = nxt_rd;
  endtask

  task automatic sample();
    o_gnt[0] = m0_if.gnt;    o_gnt[1] = m1_if.gnt;
    o_rv[0]  = m0_if.rvalid; o_rv[1]  = m1_if.rvalid;
    o_rd[0]  = m0_if.rdata;  o_rd[1]  = m1_if.rdata;
    o_wr = ram_if.wr; o_oe = ram_if.oe; o_addr = ram_if.address; o_din = ram_if.data_in;
  endtask

  task automatic phase_reset();
    cyc = 0; cnt_wr = 0; rd_seq0.delete(); run_own.delete(); run_len.delete();
    for (int i = 0; i < 2; i++) begin
      cnt_rv[i] = 0; first_gnt[i] = -1; first_rv[i] = -1; wt[i] = 0; max_wait[i] = 0;
    end
  endtask

  // One clock: load pending txns, check at negedge, advance model at posedge, retire granted beats.
  task automatic step();
    txn_t t;
    for (int i = 0; i < 2; i++) if (!req[i] && qsize(i) > 0) begin
      t = qfront(i); req[i] = 1; we[i] = t.we; addr[i] = t.addr; wdata[i] = t.wdata;
    end
    @(negedge CLK);
    sample();
    model_eval();
    chk("gnt0", 32'(o_gnt[0]), 32'(e_gnt[0]));
    chk("gnt1", 32'(o_gnt[1]), 32'(e_gnt[1]));
    chk("ram_wr", 32'(o_wr), 32'(e_wr));
    chk("ram_oe", 32'(o_oe), 32'(e_oe));
    chk("ram_addr", 32'(o_addr), 32'(e_addr));
    chk("ram_din", o_din, e_din);
    chk("rvalid0", 32'(o_rv[0]), 32'(e_rv[0]));
    chk("rvalid1", 32'(o_rv[1]), 32'(e_rv[1]));
    chk("rdata0", o_rd[0], e_rd[0]);
    chk("rdata1", o_rd[1], e_rd[1]);
    if (o_wr) cnt_wr++;
    if (o_rv[0]) rd_seq0.push_back(o_rd[0]);
    for (int i = 0; i < 2; i++) begin
      if (o_rv[i]) begin cnt_rv[i]++; if (first_rv[i] < 0) first_rv[i] = cyc; end
      if (o_gnt[i] && first_gnt[i] < 0) first_gnt[i] = cyc;
      wt[i] = (req[i] && !o_gnt[i]) ? wt[i] + 1 : 0;
      if (wt[i] > max_wait[i]) max_wait[i] = wt[i];
      if (o_gnt[i]) begin
        if (run_own.size() == 0 || run_own[run_own.size()-1] != i) begin
          run_own.push_back(i); run_len.push_back(1);
        end else run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
      end
    end
    @(posedge CLK);
    model_update();
    #1;
    for (int i = 0; i < 2; i++) if (e_gnt[i]) begin
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      req[i] = 0;
    end
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((qsize(0) > 0 || qsize(1) > 0 || req[0] || req[1]) && n < budget) begin step(); n++; end
    chk(tag, 32'(qsize(0) == 0 && qsize(1) == 0 && !req[0] && !req[1]), 32'd1);
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin req[i] = 0; we[i] = 0; addr[i] = '0; wdata[i] = '0; end
    model_reset();
    phase_reset();
    #1;
    sample();
    chk("rst_gnt0", 32'(o_gnt[0]), 32'd0);
    chk("rst_gnt1", 32'(o_gnt[1]), 32'd0);
    chk("rst_wr", 32'(o_wr), 32'd0);
    chk("rst_rv0", 32'(o_rv[0]), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RSTa = 1;
    step(); step();

    // M0-only read burst over addresses 0..3
    phase_reset();
    for (int k = 0; k < 4; k++) qpush(0, mk(1'b0, k, '0));
    drain("t2_drain", 20);
    chk("t2_first_gnt", 32'(first_gnt[0]), 32'd1);
    chk("t2_first_rv", 32'(first_rv[0]), 32'd2);
    chk("t2_rv_count", 32'(cnt_rv[0]), 32'd4);
    chk("t2_m1_rv_count", 32'(cnt_rv[1]), 32'd0);
    for (int k = 0; k < 4 && k < rd_seq0.size(); k++) chk("t2_rdata", rd_seq0[k], 32'hA000_0000 + DW'(k));

    // Both masters saturate the port; M1 wins because M0 owned last
    phase_reset();
    for (int k = 0; k < 24; k++) begin qpush(0, rnd_txn()); qpush(1, rnd_txn()); end
    drain("t3_drain", 100);
    chk("t3_runs", 32'(run_own.size()), 32'd6);
    for (int k = 0; k < 6 && k < run_own.size(); k++) begin
      chk("t3_run_owner", 32'(run_own[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_run_len", 32'(run_len[k]), 32'(MB));
    end
    chk("t3_wait0", 32'(max_wait[0] <= MB + 1), 32'd1);
    chk("t3_wait1", 32'(max_wait[1] <= MB + 1), 32'd1);

    // M1 write at the top address, M0 reads it back
    phase_reset();
    qpush(1, mk(1'b1, 10'h3FF, 32'hDEAD_BEEF));
    drain("t4_drain_w", 10);
    qpush(0, mk(1'b0, 10'h3FF, '0));
    drain("t4_drain_r", 10);
    chk("t4_wr_cycles", 32'(cnt_wr), 32'd1);
    chk("t4_rv_count", 32'(cnt_rv[0]), 32'd1);
    if (rd_seq0.size() > 0) chk("t4_rdata", rd_seq0[0], 32'hDEAD_BEEF);

    // M0's capped final beat is a read; M1 arrives in that same cycle
    phase_reset();
    for (int k = 0; k < 7; k++) qpush(0, mk(1'b1, 100 + k, $urandom));
    qpush(0, mk(1'b0, 5, '0));
    qpush(0, mk(1'b0, 6, '0));
    qpush(0, mk(1'b0, 7, '0));
    repeat (8) step();
    qpush(1, mk(1'b0, 40, '0));
    step();
    chk("t5_gnt1_decide", 32'(o_gnt[1]), 32'd0);
    chk("t5_gnt0_last", 32'(o_gnt[0]), 32'd1);
    step();
    chk("t5_rv0", 32'(o_rv[0]), 32'd1);
    chk("t5_rdata0", o_rd[0], 32'hA000_0005);
    chk("t5_gnt1", 32'(o_gnt[1]), 32'd1);
    chk("t5_rv1", 32'(o_rv[1]), 32'd0);
    drain("t5_drain", 20);

    // Single M0 write, return to idle, then a fresh request
    phase_reset();
    qpush(0, mk(1'b1, 50, 32'h1234_5678));
    drain("t6_drain", 10);
    step();
    phase_reset();
    qpush(0, mk(1'b0, 50, '0));
    repeat (3) step();
    chk("t6_first_gnt", 32'(first_gnt[0]), 32'd1);
    chk("t6_rdata", (rd_seq0.size() > 0) ? rd_seq0[0] : '0, 32'h1234_5678);

    // Random traffic on both masters
    phase_reset();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++) if (qsize(i) == 0 && $urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 10)); k++) qpush(i, rnd_txn());
      end
      step();
    end
    drain("rnd_drain", 200);
    chk("rnd_wait0", 32'(max_wait[0] <= MB + 1), 32'd1);
    chk("rnd_wait1", 32'(max_wait[1] <= MB + 1), 32'd1);

    // Reset mid-burst with a read in flight
    phase_reset();
    for (int k = 0; k < 6; k++) qpush(0, mk(1'b0, 8 + k, '0));
    repeat (4) step();
    #2;
    chk("t1_rv_before", 32'(m0_if.rvalid), 32'd1);
    RSTa = 0;
    #1;
    sample();
    chk("t1_gnt0", 32'(o_gnt[0]), 32'd0);
    chk("t1_gnt1", 32'(o_gnt[1]), 32'd0);
    chk("t1_wr", 32'(o_wr), 32'd0);
    chk("t1_oe", 32'(o_oe), 32'd0);
    chk("t1_addr", 32'(o_addr), 32'd0);
    chk("t1_din", o_din, 32'd0);
    chk("t1_rv0", 32'(o_rv[0]), 32'd0);
    chk("t1_rv1", 32'(o_rv[1]), 32'd0);
    chk("t1_rdata0", o_rd[0], 32'd0);
    chk("t1_rdata1", o_rd[1], 32'd0);
    q0.delete(); q1.delete();
    for (int i = 0; i < 2; i++) req[i] = 0;
    @(posedge CLK);
    #1 RSTa = 1;
    model_reset();
    phase_reset();
    repeat (3) step();
    chk("t1_no_rv_after", 32'(cnt_rv[0] + cnt_rv[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data RAM port between two requesters: M0 (CORE data port) and M1 (program/data loader or debug master).
- Sits between the requesters and the RAM instance.
- Drives the RAM WR/OE/ADDRESS/DATA_IN lines and routes DATA_OUT back to whichever master issued the read.
- Arbitration is round-robin with ownership hold, capped at MAX_BURST accepted beats while the other master waits.

Parameters:
- DATA_W, 32, data width of RAM and masters.
- ADDR_W, 10, RAM word-address width.
- MAX_BURST, 8, maximum consecutive accepted beats per ownership when the other master is requesting; valid range 1..255.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTa  in  1  asynchronous active-low reset.
- M0_REQ  in  1  M0 access request; held until granted.
- M0_WE  in  1  1 = write, 0 = read.
- M0_ADDR  in  ADDR_W  M0 address.
- M0_WDATA  in  DATA_W  M0 write data.
- M0_GNT  out  1  access accepted this cycle (REQ&&GNT = one beat).
- M0_RVALID  out  1  M0 read data valid.
- M0_RDATA  out  DATA_W  M0 read data.
- M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_GNT, M1_RVALID, M1_RDATA: identical to the M0 ports, for M1.
- RAM_WR  out  1  RAM write enable.
- RAM_OE  out  1  RAM read/output enable.
- RAM_ADDRESS  out  ADDR_W  RAM address.
- RAM_DATA_IN  out  DATA_W  RAM write data.
- RAM_DATA_OUT  in  DATA_W  RAM read data, valid the cycle after OE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- FSM states: IDLE, OWN0, OWN1. Reset state IDLE.
- Registered state: last_owner (reset 0), beat_cnt (8 bit, reset 0), rd_pend (reset 0), rd_tag (reset 0).
- Reset values: all GNT = 0; RVALID = 0; RDATA = 0; RAM_WR = 0; RAM_OE = 0; RAM_ADDRESS = 0; RAM_DATA_IN = 0.
- IDLE: GNT = 0. Next state:
  - only M0_REQ -> OWN0;
  - only M1_REQ -> OWN1;
  - both -> OWN of the master != last_owner.
  - Arbitration latency is 1 cycle from REQ to first GNT.
- OWNi:
  - M{i}_GNT = M{i}_REQ, combinational. The other GNT = 0.
  - RAM lines are muxed combinationally from master i:
    - RAM_WR = REQ_i & WE_i;
    - RAM_OE = REQ_i & ~WE_i;
    - ADDRESS and DATA_IN taken from master i;
    - all RAM lines are 0 when no beat is accepted.
  - Each accepted beat increments beat_cnt (saturating at 255).
- Leaving OWNi (evaluated at each edge):
  - REQ_i = 0: go to OWN(other) if the other master requests, else IDLE. last_owner <= i.
  - Beat accepted, beat_cnt+1 == MAX_BURST, and other REQ = 1: go to OWN(other) at this edge. last_owner <= i.
  - beat_cnt+1 == MAX_BURST with the other master idle: stay in OWNi; beat_cnt keeps counting and saturates at 255.
  - beat_cnt clears on every ownership change.
- Read return:
  - An accepted read sets rd_pend = 1 and rd_tag = i at the edge.
  - Next cycle: M{rd_tag}_RVALID = 1 and M{rd_tag}_RDATA = RAM_DATA_OUT, combinational passthrough. The other RDATA holds 0.
  - Back-to-back reads give one RVALID per cycle.
  - A switch of ownership directly after a read still returns that data to the original master.
- Writes: no response; a write completes at the accepted edge.
- Simultaneous events:
  - Owner drop and other master's REQ in the same cycle: handover with no idle cycle; the first GNT to the new owner comes in the next cycle.
  - A master is never granted in the cycle ownership is decided.
- Master obligations: REQ, WE, ADDR and WDATA must stay stable while REQ = 1 and GNT = 0. The arbiter does not check this.
- Reset mid-operation: immediate return to IDLE.
  - All outputs take their reset values asynchronously.
  - A pending read is dropped; no RVALID after reset.
- Fairness: a continuously requesting master waits at most MAX_BURST+1 cycles for its first GNT.

Decomposition:
- Package dmem_arb_pkg: typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t; localparam N_MASTERS = 2.
- One sub-module, dmem_arb_mux: purely combinational RAM request mux and read-data demux, selected by owner and rd_tag.
- The FSM, counters and read tracking stay in the top-level dmem_arbiter.

Test Plan:
1. Reset: RSTa = 0 mid-burst with rd_pend = 1 -> all outputs 0 immediately; no RVALID after RSTa rises; state IDLE.
2. M0-only read burst at addresses 0..3, RAM preloaded with A0+k -> GNT from cycle 1; M0_RVALID on cycles 2..5 with RDATA = A0..A3; M1 outputs 0.
3. Both masters request continuously, MAX_BURST = 8, last_owner = 0 -> M1 owns first; exactly 8 M1 beats, then 8 M0 beats, alternating; no master waits more than 9 cycles.
4. M1 writes 0xDEADBEEF to address 0x3FF, then M0 reads 0x3FF -> M0_RDATA = 0xDEADBEEF; RAM_WR is high for exactly one cycle.
5. M0 read at address 5 is its final beat and M1_REQ rises in the same cycle -> M0_RVALID next cycle with mem[5]; M1_GNT that same cycle; M1_RVALID stays 0.
6. M0 single write then drops REQ, M1 idle -> state OWN0 -> IDLE; beat_cnt cleared; a later M0_REQ is granted after 1 cycle.
